// File: rtl/ball_motion_ctrl_pkg.sv
// Shared keycodes, direction/state encodings and screen bounds for the ball
// motion controller.
package ball_pkg;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  localparam int unsigned SCR_X_MIN = 0;
  localparam int unsigned SCR_X_MAX = 639;
  localparam int unsigned SCR_Y_MIN = 0;
  localparam int unsigned SCR_Y_MAX = 479;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_A    = 3'd1,
    DIR_D    = 3'd2,
    DIR_W    = 3'd3,
    DIR_S    = 3'd4,
    DIR_AW   = 3'd5,
    DIR_AS   = 3'd6,
    DIR_DW   = 3'd7
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BOUND = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  function automatic dir_t key2dir(input logic [7:0] code);
    case (code)
      KEY_A:   return DIR_A;
      KEY_D:   return DIR_D;
      KEY_W:   return DIR_W;
      KEY_S:   return DIR_S;
      default: return DIR_NONE;
    endcase
  endfunction

  // DS has no code of its own and reports as D.
  function automatic dir_t diag_dir(input dir_t x, input dir_t y);
    if (x == DIR_NONE) return y;
    if (y == DIR_NONE) return x;
    if (x == DIR_A)    return (y == DIR_W) ? DIR_AW : DIR_AS;
    return (y == DIR_W) ? DIR_DW : DIR_D;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Motion command handshake between the controller and the ball position register.
interface ball_motion_ctrl_if;
  logic [9:0] Motion_X;
  logic [9:0] Motion_Y;
  logic       move_valid;
  logic       move_ready;

  modport master (output Motion_X, output Motion_Y, output move_valid, input move_ready);
  modport slave  (input Motion_X, input Motion_Y, input move_valid, output move_ready);
endinterface

// File: rtl/ball_motion_ctrl_key_arbiter.sv
// Maps four keycode slots to directions and picks one with sticky priority:
// the current direction wins if still held, else the lowest slot on this axis.
module key_arbiter
  import ball_pkg::*;
#(
  parameter bit USE_X = 1'b1,
  parameter bit USE_Y = 1'b1
) (
  input  logic [3:0][7:0] slots_i,
  input  dir_t            cur_i,
  output dir_t            dir_o,
  output logic            hit_o
);

  function automatic logic on_axis(input dir_t d);
    return (USE_X && (d == DIR_A || d == DIR_D)) ||
           (USE_Y && (d == DIR_W || d == DIR_S));
  endfunction

  always_comb begin
    dir_o = cur_i;
    hit_o = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (on_axis(cur_i) && key2dir(slots_i[i]) == cur_i) hit_o = 1'b1;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hit_o && on_axis(key2dir(slots_i[i]))) begin
        dir_o = key2dir(slots_i[i]);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: frame tick -> key scan -> wall bounce -> command.
// Define BALL_DIAG_EN for independent X/Y key selection (diagonal motion).
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int unsigned STEP  = 1,
  parameter int unsigned X_MIN = SCR_X_MIN,
  parameter int unsigned X_MAX = SCR_X_MAX,
  parameter int unsigned Y_MIN = SCR_Y_MIN,
  parameter int unsigned Y_MAX = SCR_Y_MAX
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [7:0]         keycode0,
  input  logic [7:0]         keycode1,
  input  logic [7:0]         keycode2,
  input  logic [7:0]         keycode3,
  input  logic [9:0]         BallX,
  input  logic [9:0]         BallY,
  input  logic [9:0]         BallS,
  ball_motion_ctrl_if.master mv,
  output logic [7:0]         overrun_cnt,
  output logic [2:0]         cur_dir
);

  localparam logic [9:0]  STEP_P = 10'(STEP);
  localparam logic [9:0]  STEP_N = ~STEP_P + 10'd1;
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] XMIN_W = 11'(X_MIN);
  localparam logic [10:0] XMAX_W = 11'(X_MAX);
  localparam logic [10:0] YMIN_W = 11'(Y_MIN);
  localparam logic [10:0] YMAX_W = 11'(Y_MAX);

  logic            fs1_q, fs2_q, fs3_q, tick;
  state_t          state_q, state_d;
  dir_t            cur_dir_q, cur_dir_d, scan_dir;
  logic [9:0]      prop_x_q, prop_x_d, prop_y_q, prop_y_d;
  logic [9:0]      mx_q, mx_d, my_q, my_d;
  logic [9:0]      scan_px, scan_py, bnc_x, bnc_y;
  logic            valid_q, valid_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [3:0][7:0] slots;

  assign slots = {keycode3, keycode2, keycode1, keycode0};
  assign tick  = fs2_q & ~fs3_q;

`ifdef BALL_DIAG_EN
  dir_t xdir_q, ydir_q, xsel, ysel, scan_xdir, scan_ydir;
  logic xhit, yhit;

  key_arbiter #(.USE_X(1'b1), .USE_Y(1'b0)) u_arb_x (
    .slots_i(slots), .cur_i(xdir_q), .dir_o(xsel), .hit_o(xhit)
  );
  key_arbiter #(.USE_X(1'b0), .USE_Y(1'b1)) u_arb_y (
    .slots_i(slots), .cur_i(ydir_q), .dir_o(ysel), .hit_o(yhit)
  );

  // An axis with no key held keeps its previous (possibly bounced) motion.
  always_comb begin
    scan_xdir = xhit ? xsel : xdir_q;
    scan_ydir = yhit ? ysel : ydir_q;
    scan_dir  = diag_dir(scan_xdir, scan_ydir);
    scan_px   = mx_q;
    scan_py   = my_q;
    if (xhit) scan_px = (xsel == DIR_D) ? STEP_P : STEP_N;
    if (yhit) scan_py = (ysel == DIR_S) ? STEP_P : STEP_N;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      xdir_q <= DIR_NONE;
      ydir_q <= DIR_NONE;
    end else if (state_q == ST_SCAN) begin
      xdir_q <= scan_xdir;
      ydir_q <= scan_ydir;
    end
  end
`else
  dir_t sel;
  logic hit;

  key_arbiter #(.USE_X(1'b1), .USE_Y(1'b1)) u_arb (
    .slots_i(slots), .cur_i(cur_dir_q), .dir_o(sel), .hit_o(hit)
  );

  // No mapped key: direction and previous (possibly bounced) motion both persist.
  always_comb begin
    scan_dir = hit ? sel : cur_dir_q;
    scan_px  = mx_q;
    scan_py  = my_q;
    if (hit) begin
      scan_px = '0;
      scan_py = '0;
      case (sel)
        DIR_A:   scan_px = STEP_N;
        DIR_D:   scan_px = STEP_P;
        DIR_W:   scan_py = STEP_N;
        DIR_S:   scan_py = STEP_P;
        default: ;
      endcase
    end
  end
`endif

  // Bounds use 11-bit sums so edge positions near 1023 cannot wrap.
  always_comb begin
    bnc_x = prop_x_q;
    bnc_y = prop_y_q;
    if (prop_x_q != '0 && !prop_x_q[9] &&
        ({1'b0, BallX} + {1'b0, BallS} + STEP_W) > XMAX_W)          bnc_x = STEP_N;
    else if (prop_x_q[9] && {1'b0, BallX} < (XMIN_W + {1'b0, BallS} + STEP_W)) bnc_x = STEP_P;
    if (prop_y_q != '0 && !prop_y_q[9] &&
        ({1'b0, BallY} + {1'b0, BallS} + STEP_W) > YMAX_W)          bnc_y = STEP_N;
    else if (prop_y_q[9] && {1'b0, BallY} < (YMIN_W + {1'b0, BallS} + STEP_W)) bnc_y = STEP_P;
  end

  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    prop_x_d  = prop_x_q;
    prop_y_d  = prop_y_q;
    mx_d      = mx_q;
    my_d      = my_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SCAN;
      ST_SCAN: begin
        prop_x_d  = scan_px;
        prop_y_d  = scan_py;
        cur_dir_d = scan_dir;
        state_d   = ST_BOUND;
      end
      ST_BOUND: begin
        mx_d    = bnc_x;
        my_d    = bnc_y;
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (mv.move_ready) begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (tick && state_q != ST_IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fs1_q     <= 1'b0;
      fs2_q     <= 1'b0;
      fs3_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cur_dir_q <= DIR_NONE;
      prop_x_q  <= '0;
      prop_y_q  <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= '0;
    end else begin
      fs1_q     <= frame_clk;
      fs2_q     <= fs1_q;
      fs3_q     <= fs2_q;
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      prop_x_q  <= prop_x_d;
      prop_y_q  <= prop_y_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mv.Motion_X  = mx_q;
  assign mv.Motion_Y  = my_q;
  assign mv.move_valid = valid_q;
  assign overrun_cnt  = ovr_q;
  assign cur_dir      = cur_dir_q;

endmodule
